// File: rtl/aes_inv_key_gen_if.sv
// Request/response bundle between the inverse-cipher round controller, the shared
// S-box and the inverse key schedule.
interface aes_inv_key_gen_if;
  logic             en;
  logic             start;
  logic             next_rnd;
  logic [0:3][31:0] key_i;
  logic [31:0]      sub_i;
  logic [31:0]      sub_o;
  logic [0:3][31:0] key_o;
  logic [3:0]       rnd_o;
  logic             key_vld;
  logic             busy;
  logic             done;

  modport master (
    output en, start, next_rnd, key_i, sub_i,
    input  sub_o, key_o, rnd_o, key_vld, busy, done
  );

  modport slave (
    input  en, start, next_rnd, key_i, sub_i,
    output sub_o, key_o, rnd_o, key_vld, busy, done
  );
endinterface

// File: rtl/aes_inv_key_gen.sv
// AES-128 inverse key schedule: steps from the round-NR key back to the cipher key.
// Optional AES_INV_KEY_DONE_IRQ_EN adds irq_ack/done_irq with a sticky completion flag.
module aes_inv_key_gen #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic clk,
  input  logic rst,
`ifdef AES_INV_KEY_DONE_IRQ_EN
  input  logic irq_ack,
  output logic done_irq,
`endif
  aes_inv_key_gen_if.slave bus
);

  if (NK != 4) begin : g_nk_check
    $error("aes_inv_key_gen supports NK=4 only");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CALC,
    SUB,
    DONE
  } state_t;

  localparam logic [3:0] NR_W = 4'(NR);

  state_t           state_q;
  state_t           state_d;
  logic [0:3][31:0] key_q;
  logic [3:0]       rnd_q;
  logic [31:0]      p1_q;
  logic [31:0]      p2_q;
  logic [31:0]      p3_q;
  logic [31:0]      p0;
  logic             load;
  logic             calc;
  logic             upd;

  // Rcon for round r: x^(r-1) in GF(2^8), so the table depth follows NR.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int unsigned i = 2; i <= 15; i++) begin
      if (i <= 32'(r)) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
    return rc;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        IDLE, DONE: if (bus.start)    state_d = WAIT;
        WAIT:       if (bus.next_rnd) state_d = CALC;
        CALC:                         state_d = SUB;
        SUB:        state_d = (rnd_q <= 4'd1) ? DONE : WAIT;
        default:                      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sub_o   = '0;
    bus.key_vld = 1'b0;
    bus.busy    = 1'b0;
    case (state_q)
      WAIT, DONE: bus.key_vld = 1'b1;
      CALC:       bus.busy    = 1'b1;
      SUB: begin
        bus.busy  = 1'b1;
        bus.sub_o = {p3_q[23:0], p3_q[31:24]};
      end
      default: ;
    endcase
    bus.done = bus.key_vld && (rnd_q == 4'd0);
  end

  assign bus.key_o = key_q;
  assign bus.rnd_o = rnd_q;

  assign load = bus.en && bus.start && (state_q == IDLE || state_q == DONE);
  assign calc = bus.en && (state_q == CALC);
  assign upd  = bus.en && (state_q == SUB);
  assign p0   = key_q[0] ^ bus.sub_i ^ {rcon(rnd_q), 24'h0};

  // Words 1..3 are registered in CALC so the S-box operand is stable for all of SUB.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      rnd_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      p3_q  <= '0;
    end else begin
      if (load) begin
        key_q <= bus.key_i;
        rnd_q <= NR_W;
      end else if (upd) begin
        key_q <= {p0, p1_q, p2_q, p3_q};
        rnd_q <= (rnd_q != 4'd0) ? rnd_q - 4'd1 : 4'd0;
      end
      if (calc) begin
        p3_q <= key_q[3] ^ key_q[2];
        p2_q <= key_q[2] ^ key_q[1];
        p1_q <= key_q[1] ^ key_q[0];
      end
    end
  end

`ifdef AES_INV_KEY_DONE_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst)                                    done_irq <= 1'b0;
    else if (upd && state_d == DONE)            done_irq <= 1'b1;
    else if (bus.en && irq_ack)                 done_irq <= 1'b0;
  end
`endif

endmodule
